// File: rtl/ppu_sprite_pkg.sv
// Shared definitions for the per-scanline sprite engine: load_data field layout,
// FSM encoding and the pattern bit-select helper. Used with or without SPR_ZERO_HIT_EN.
package ppu_sprite_pkg;

    localparam int SPR_W      = 8;
    localparam int X_LSB      = 0;
    localparam int P0_LSB     = 8;
    localparam int PAL_LSB    = 16;
    localparam int BEHIND_BIT = 21;
    localparam int HFLIP_BIT  = 22;
    localparam int P1_LSB     = 24;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Column within the sprite to pattern bit; bit 7 is the leftmost pixel unless flipped.
    function automatic logic [2:0] pattern_bit(input logic [2:0] col, input logic hflip);
        return hflip ? col : (3'd7 - col);
    endfunction

endpackage

// File: rtl/sprite_slot.sv
// One active-bank sprite slot: captures an entry on swap and decodes its pixel at x.
// SPR_ZERO_HIT_EN adds per-slot storage of the sprite-0 flag.
module sprite_slot
    import ppu_sprite_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_swap,
    input  logic        i_valid,
    input  logic        i_zero,
    input  logic [31:0] i_data,
    input  logic [8:0]  i_x,
    output logic        o_in_range,
    output logic [1:0]  o_px,
    output logic [1:0]  o_pal,
    output logic        o_behind,
    output logic        o_zero
);

    logic [31:0] r_data;
    logic        r_valid;
    logic [8:0]  w_sx;
    logic [2:0]  w_col;
    logic [2:0]  w_bit;
    logic [7:0]  w_p0;
    logic [7:0]  w_p1;
    logic        w_unused_bits;

    // Active entry register, reloaded from the shadow bank at line start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= 32'd0;
            r_valid <= 1'b0;
        end else if (i_swap) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    // Nine-bit compare so a sprite near the right edge never wraps to x<8.
    assign w_sx       = {1'b0, r_data[X_LSB +: 8]};
    assign o_in_range = r_valid && (i_x >= w_sx) && (i_x < (w_sx + 9'(SPR_W)));
    assign w_col      = i_x[2:0] - r_data[X_LSB +: 3];
    assign w_bit      = pattern_bit(w_col, r_data[HFLIP_BIT]);
    assign w_p0       = r_data[P0_LSB +: 8];
    assign w_p1       = r_data[P1_LSB +: 8];
    assign o_px       = {w_p1[w_bit], w_p0[w_bit]};
    assign o_pal      = r_data[PAL_LSB +: 2];
    assign o_behind   = r_data[BEHIND_BIT];
    assign w_unused_bits = ^{r_data[20:18], r_data[23]};

`ifdef SPR_ZERO_HIT_EN
    logic r_zero;

    // Sprite-0 flag travels with the entry into the active bank.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_zero <= 1'b0;
        end else if (i_swap) begin
            r_zero <= i_zero;
        end
    end

    assign o_zero = r_zero;
`else
    logic w_unused_zero;
    assign w_unused_zero = i_zero;
    assign o_zero        = 1'b0;
`endif

endmodule

// File: rtl/sprite_line_unit.sv
// Per-scanline sprite engine: shadow bank fill, line-start swap, priority-resolved pixel output.
// Optional sprite-0 hit detection is enabled by defining SPR_ZERO_HIT_EN.
module sprite_line_unit
    import ppu_sprite_pkg::*;
#(
    parameter int SLOTS = 8,
    parameter int IW    = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  ctrl1,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic        load_zero,
    input  logic        pix_en,
    input  logic [8:0]  x,
    input  logic [4:0]  bg,
    output logic [4:0]  color,
    output logic        hit,
    output logic        overflow,
    output logic        sprite0_hit
);

    localparam logic [IW:0] FULL_CNT = (IW+1)'(SLOTS);

    logic [31:0]      r_sh_data [SLOTS];
    logic [IW:0]      r_cnt;
    state_t           r_state;
    state_t           w_state_nx;
    logic [4:0]       r_color;
    logic             r_hit;
    logic             r_ovf;
    logic             w_accept;
    logic             w_swap;
    logic [IW-1:0]    w_wr_idx;
    logic [SLOTS-1:0] w_sh_zero;
    logic [SLOTS-1:0] w_valid_mask;
    logic [SLOTS-1:0] w_in_range;
    logic [SLOTS-1:0] w_opaque;
    logic [SLOTS-1:0] w_first;
    logic [SLOTS-1:0] w_behind;
    logic [SLOTS-1:0] w_zero;
    logic [1:0]       w_px  [SLOTS];
    logic [1:0]       w_pal [SLOTS];
    logic [1:0]       w_win_px;
    logic [1:0]       w_win_pal;
    logic             w_win_behind;
    logic             w_win;
    logic             w_clip;
    logic [4:0]       w_color_nx;
    logic             w_hit_nx;
    logic             w_s0_nx;
    logic             w_unused_ctrl;

    assign load_ready = (r_cnt < FULL_CNT);
    assign w_accept   = load_valid && load_ready;
    assign w_swap     = line_start && !frame_start;
    // On a swap the incoming entry lands in slot 0 of the freshly emptied shadow bank.
    assign w_wr_idx   = w_swap ? {IW{1'b0}} : r_cnt[IW-1:0];
    assign w_unused_ctrl = ^{ctrl1[7:5], ctrl1[3], ctrl1[1:0]};

    // Shadow bank fill counter and entry storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= {(IW+1){1'b0}};
            for (int i = 0; i < SLOTS; i++) begin
                r_sh_data[i] <= 32'd0;
            end
        end else begin
            if (w_swap) begin
                r_cnt <= w_accept ? {{IW{1'b0}}, 1'b1} : {(IW+1){1'b0}};
            end else if (w_accept) begin
                r_cnt <= r_cnt + {{IW{1'b0}}, 1'b1};
            end
            if (w_accept) begin
                r_sh_data[w_wr_idx] <= load_data;
            end
        end
    end

`ifdef SPR_ZERO_HIT_EN
    logic [SLOTS-1:0] r_sh_zero;
    logic             r_s0;

    // Shadow-bank sprite-0 flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_zero <= {SLOTS{1'b0}};
        end else if (w_accept) begin
            r_sh_zero[w_wr_idx] <= load_zero;
        end
    end

    // Sticky sprite-0 hit, cleared only by frame start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s0 <= 1'b0;
        end else if (frame_start) begin
            r_s0 <= 1'b0;
        end else if (pix_en && w_s0_nx) begin
            r_s0 <= 1'b1;
        end
    end

    assign w_sh_zero   = r_sh_zero;
    assign sprite0_hit = r_s0;
`else
    logic w_unused_zero;
    assign w_unused_zero = ^{load_zero, w_s0_nx};
    assign w_sh_zero     = {SLOTS{1'b0}};
    assign sprite0_hit   = 1'b0;
`endif

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        assign w_valid_mask[g] = (r_cnt > (IW+1)'(g));
        assign w_opaque[g]     = w_in_range[g] && (w_px[g] != 2'b00);

        sprite_slot u_slot (
            .clock      (clock),
            .reset_n    (reset_n),
            .i_swap     (w_swap),
            .i_valid    (w_valid_mask[g]),
            .i_zero     (w_sh_zero[g]),
            .i_data     (r_sh_data[g]),
            .i_x        (x),
            .o_in_range (w_in_range[g]),
            .o_px       (w_px[g]),
            .o_pal      (w_pal[g]),
            .o_behind   (w_behind[g]),
            .o_zero     (w_zero[g])
        );
    end

    // Isolate the lowest-index opaque slot; a behind-bg winner still masks later slots.
    assign w_first = w_opaque & (~w_opaque + {{(SLOTS-1){1'b0}}, 1'b1});
    assign w_win   = |w_opaque;

    // One-hot select of the winning slot's pixel attributes.
    always_comb begin
        w_win_px     = 2'b00;
        w_win_pal    = 2'b00;
        w_win_behind = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            w_win_px     = w_win_px  | ({2{w_first[i]}} & w_px[i]);
            w_win_pal    = w_win_pal | ({2{w_first[i]}} & w_pal[i]);
            w_win_behind = w_win_behind | (w_first[i] & w_behind[i]);
        end
    end

    assign w_clip = !ctrl1[4] || (!ctrl1[2] && (x < 9'd8));

    // Pixel composition for the next registered output.
    always_comb begin
        w_color_nx = bg;
        w_hit_nx   = 1'b0;
        w_s0_nx    = 1'b0;
        if ((r_state == S_RUN) && !w_clip) begin
            w_hit_nx = w_win;
            w_s0_nx  = (|(w_opaque & w_zero)) && (bg[1:0] != 2'b00) && (x != 9'd255);
            if (w_win && !(w_win_behind && (bg[1:0] != 2'b00))) begin
                w_color_nx = {1'b1, w_win_pal, w_win_px};
            end else begin
                w_color_nx = bg;
            end
        end else begin
            w_color_nx = bg;
            w_hit_nx   = 1'b0;
            w_s0_nx    = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state: frame start always returns to idle, line start arms the pixel path.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_nx = S_IDLE;
                end else if (line_start) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (frame_start) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_RUN;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Output pixel register (holds while pix_en is low) and sticky overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_color <= 5'd0;
            r_hit   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (pix_en) begin
                r_color <= w_color_nx;
                r_hit   <= w_hit_nx;
            end
            if (frame_start) begin
                r_ovf <= 1'b0;
            end else if (load_valid && !load_ready) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign color    = r_color;
    assign hit      = r_hit;
    assign overflow = r_ovf;

endmodule
